// File: rtl/bcd_display_engine.sv
// Sequential double-dabble binary-to-BCD converter with registered 7-segment outputs.
// Define BCD_LEADING_ZERO_BLANK_EN to blank magnitude digits above the most significant nonzero one.
module bcd_display_engine #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    negative,
    output logic                    overflow,
    output logic [7*(DIGITS+1)-1:0] seg
);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * (DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mag_q;
    logic [BW-1:0]    acc_q;
    logic [5:0]       cnt_q;
    logic             neg_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             negative_q;
    logic             overflow_q;
    logic [BW-1:0]    bcd_q;
    logic [SW-1:0]    seg_q;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    acc_d;
    logic [WIDTH-1:0] mag_d;
    logic             carry;
    logic [SW-1:0]    seg_d;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    // One double-dabble step: add 3 to digits >= 5, then shift {acc, mag} left by one.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        carry = adj[BW-1];
        acc_d = {adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
    end

    // NOTE: every variable in a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        logic seen_nz;
        seg_d   = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (acc_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
            if (ovf_q)                                seg_d[7*i +: 7] = 7'h40;
            else if (LZ_BLANK && !seen_nz && i != 0) seg_d[7*i +: 7] = 7'h00;
            else                                      seg_d[7*i +: 7] = seg_of(acc_q[4*i +: 4]);
        end
        seg_d[7*DIGITS +: 7] = neg_q ? 7'h40 : 7'h00;
    end

    // NOTE: sequential state uses non-blocking assignments only; busy/done are registered
    // from the current state, so they lag the state by one edge and fall together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= '0;
        end else begin
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == ENCODE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (SIGNED != 0 && value[WIDTH-1]) begin
                            mag_q <= -value;
                            neg_q <= 1'b1;
                        end else begin
                            mag_q <= value;
                            neg_q <= 1'b0;
                        end
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= 6'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    mag_q <= mag_d;
                    ovf_q <= ovf_q | carry;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_q <= ENCODE;
                end
                ENCODE: begin
                    bcd_q      <= acc_q;
                    negative_q <= neg_q;
                    overflow_q <= ovf_q;
                    seg_q      <= seg_d;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign seg      = seg_q;

endmodule
